// File: rtl/or_mod_v2.sv
// Registered bitwise-OR unit for the ALU result mux: c <= a | b every rising clk edge.
// Optional status flags (zero / all-ones / popcount of the result) are enabled by OR_MOD_V2_FLAGS_EN.
module or_mod_v2 #(
    parameter int size = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [size-1:0]            a,
    input  logic [size-1:0]            b,
    output logic [size-1:0]            c
`ifdef OR_MOD_V2_FLAGS_EN
    ,
    output logic                       c_zero,
    output logic                       c_ones,
    output logic [$clog2(size+1)-1:0]  c_pop
`endif
);

    localparam int POP_W = $clog2(size + 1);

    // Ones count over the full operand width; loop unrolls into an adder tree.
    function automatic logic [POP_W-1:0] pop_count(input logic [size-1:0] v);
        logic [POP_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < size; i++) begin
            acc = acc + POP_W'(v[i]);
        end
        return acc;
    endfunction

    // Stage p0: combinational result, purely bitwise so X on one bit stays on that bit.
    logic [size-1:0] or_p0;

    always_comb begin
        or_p0 = a | b;
    end

    // Stage p1: result register, cleared asynchronously so the output is never stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= '0;
        end else begin
            c <= or_p0;
        end
    end

`ifdef OR_MOD_V2_FLAGS_EN
    logic             zero_p0;
    logic             ones_p0;
    logic [POP_W-1:0] pop_p0;

    // Flags derive from the same p0 value as c so all outputs update together.
    always_comb begin
        zero_p0 = ~|or_p0;
        ones_p0 = &or_p0;
        pop_p0  = pop_count(or_p0);
    end

    // Stage p1: flag registers; reset values describe a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_zero <= 1'b1;
            c_ones <= 1'b0;
            c_pop  <= '0;
        end else begin
            c_zero <= zero_p0;
            c_ones <= ones_p0;
            c_pop  <= pop_p0;
        end
    end
`endif

endmodule

// File: tb/tb_or_mod_v2.sv
// Directed bench for or_mod_v2: reset, basic OR, latency, exhaustive 4-bit sweep,
// async reset mid-run, and 1-bit / 16-bit width instances.
module tb_or_mod_v2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  a, b, c;
    logic [15:0] a16, b16, c16;
    logic [0:0]  a1, b1, c1;
    int          n_cmp;
    int          n_bad;
`ifdef OR_MOD_V2_FLAGS_EN
    logic        c_zero, c_ones, z16, o16, z1, o1;
    logic [2:0]  c_pop;
    logic [4:0]  p16;
    logic [0:0]  p1;
`endif

    or_mod_v2 #(.size(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c)
`ifdef OR_MOD_V2_FLAGS_EN
        , .c_zero(c_zero), .c_ones(c_ones), .c_pop(c_pop)
`endif
    );

    or_mod_v2 #(.size(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .c(c16)
`ifdef OR_MOD_V2_FLAGS_EN
        , .c_zero(z16), .c_ones(o16), .c_pop(p16)
`endif
    );

    or_mod_v2 #(.size(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1)
`ifdef OR_MOD_V2_FLAGS_EN
        , .c_zero(z1), .c_ones(o1), .c_pop(p1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] vv;
        logic [3:0] exp_c;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        a = 4'hF; b = 4'hF;
        a16 = 16'h0; b16 = 16'h0;
        a1 = 1'b0; b1 = 1'b0;

        // Reset held through several edges with all-ones operands.
        repeat (3) tick();
        chk("reset_c", 64'(c), 64'h0);
        chk("reset_c16", 64'(c16), 64'h0);
`ifdef OR_MOD_V2_FLAGS_EN
        chk("reset_zero", 64'(c_zero), 64'h1);
        chk("reset_ones", 64'(c_ones), 64'h0);
        chk("reset_pop", 64'(c_pop), 64'h0);
`endif

        // Deassertion alone changes nothing.
        #2 rst_n = 1'b1;
        #1 chk("deassert_hold", 64'(c), 64'h0);

        // Basic OR.
        a = 4'hA; b = 4'h5;
        tick();
        chk("basic_or", 64'(c), 64'hF);
`ifdef OR_MOD_V2_FLAGS_EN
        chk("basic_ones", 64'(c_ones), 64'h1);
        chk("basic_pop", 64'(c_pop), 64'h4);
        chk("basic_zero", 64'(c_zero), 64'h0);
`endif

        // Latency: value appears only after the capturing edge and holds between edges.
        a = 4'h0; b = 4'h0;
        tick();
        chk("lat_zero", 64'(c), 64'h0);
        a = 4'h3;
        #2 chk("lat_before_edge", 64'(c), 64'h0);
        tick();
        chk("lat_after_edge", 64'(c), 64'h3);
        #2 a = 4'h8;
        #1 chk("lat_hold", 64'(c), 64'h3);
        tick();
        chk("lat_next", 64'(c), 64'h8);

        // Exhaustive sweep through all 256 operand pairs, then wrap to zero.
        for (int v = 0; v <= 256; v++) begin
            vv = 8'(v);
            {a, b} = vv;
            exp_c = vv[7:4] | vv[3:0];
            tick();
            chk("sweep", 64'(c), 64'(exp_c));
        end
        chk("wrap_c", 64'(c), 64'h0);
`ifdef OR_MOD_V2_FLAGS_EN
        chk("wrap_zero", 64'(c_zero), 64'h1);
`endif

        // Width instances.
        a16 = 16'h00F0; b16 = 16'h0F00;
        a1 = 1'b1; b1 = 1'b0;
        tick();
        chk("w16_c", 64'(c16), 64'h0FF0);
        chk("w1_one", 64'(c1), 64'h1);
`ifdef OR_MOD_V2_FLAGS_EN
        chk("w16_pop", 64'(p16), 64'h8);
        chk("w1_ones", 64'(o1), 64'h1);
`endif
        a1 = 1'b0;
        tick();
        chk("w1_zero", 64'(c1), 64'h0);

        // Async reset between edges clears c without a clock edge.
        a = 4'hC; b = 4'h4;
        tick();
        chk("pre_async", 64'(c), 64'hC);
        #1 rst_n = 1'b0;
        #1 chk("async_clear", 64'(c), 64'h0);
        chk("async_clear16", 64'(c16), 64'h0);
`ifdef OR_MOD_V2_FLAGS_EN
        chk("async_zero", 64'(c_zero), 64'h1);
`endif
        tick();
        rst_n = 1'b1;
        a = 4'h6; b = 4'h1;
        tick();
        chk("post_reset", 64'(c), 64'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
